// File: rtl/load_store_align_unit_if.sv
// Datapath request/response and data-memory bus bundle for load_store_align_unit.
// The unit connects through the slave modport; the environment uses master.
interface load_store_align_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BYTES-1:0]      mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_align_unit.sv
// Load/store sizing and alignment unit; splits word-crossing accesses into two beats.
// Optional macro LSAU_MISALIGN_TRAP_EN: crossing accesses return resp_err instead.
module load_store_align_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic                     clk,
  input logic                     reset,
  load_store_align_unit_if.slave  bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS_W = $clog2(BYTES);

`ifdef LSAU_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;
`endif

  function automatic logic [DATA_WIDTH-1:0] lanes(input logic [BYTES-1:0] be);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < BYTES; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Fill above the access size with the top bit of the access when signed.
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] raw,
                                                   input logic [DATA_WIDTH-1:0] nmask,
                                                   input logic sgn);
    logic [DATA_WIDTH-1:0] top;
    logic fill;
    top  = nmask & ~(nmask >> 1);
    fill = sgn & (|(raw & top));
    return (raw & nmask) | (fill ? ~nmask : {DATA_WIDTH{1'b0}});
  endfunction

  state_t                state_q, state_d;
  logic                  write_q, write_d, signed_q, signed_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BYTES-1:0]      mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic                    idle_s, split_s, dword_err_s, trap_s, finish_s;
  logic [1:0]              sel_size_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s, align_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s, nmask_s, cur_s, ld_raw_s, ld_s;
  logic [3:0]              n_s;
  logic [OFS_W-1:0]        ofs_s;
  logic [4:0]              end_s;
  logic [2*BYTES-1:0]      len_be_s, be_wide_s;
  logic [2*DATA_WIDTH-1:0] wd_wide_s, asm_s;

  // In IDLE decisions use the live request; afterwards the latched copy.
  assign idle_s      = (state_q == IDLE);
  assign sel_size_s  = idle_s ? bus.req_size  : size_q;
  assign sel_addr_s  = idle_s ? bus.req_addr  : addr_q;
  assign sel_wdata_s = idle_s ? bus.req_wdata : wdata_q;
  assign n_s         = 4'd1 << sel_size_s;
  assign ofs_s       = sel_addr_s[OFS_W-1:0];
  assign end_s       = 5'(ofs_s) + 5'(n_s);
  assign split_s     = (end_s > 5'(BYTES));
  assign dword_err_s = (DATA_WIDTH == 32) && (sel_size_s == 2'b11);
  assign align_s     = {sel_addr_s[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
  // Low half of the widened enables/data is beat 0, high half is beat 1.
  assign len_be_s    = ((2*BYTES)'(1) << n_s) - (2*BYTES)'(1);
  assign be_wide_s   = len_be_s << ofs_s;
  assign wd_wide_s   = {{DATA_WIDTH{1'b0}}, sel_wdata_s} << {ofs_s, 3'b000};
  assign nmask_s     = lanes(len_be_s[BYTES-1:0]);
  assign cur_s       = bus.mem_rdata & lanes(mem_be_q);
  assign asm_s       = (state_q == ACC0) ? {{DATA_WIDTH{1'b0}}, cur_s} : {cur_s, rdata_q};
  assign ld_raw_s    = DATA_WIDTH'(asm_s >> {ofs_s, 3'b000});
  assign ld_s        = write_q ? {DATA_WIDTH{1'b0}} : extend(ld_raw_s, nmask_s, signed_q);
`ifdef LSAU_MISALIGN_TRAP_EN
  assign trap_s      = split_s;
`else
  assign trap_s      = 1'b0;
`endif

  // Next-state, request latching, memory beat setup and response generation.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    signed_d     = signed_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = {DATA_WIDTH{1'b0}};
    finish_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          signed_d = bus.req_signed;
          size_d   = bus.req_size;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (dword_err_s || trap_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ACC0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_write;
            mem_addr_d  = align_s;
            mem_be_d    = be_wide_s[BYTES-1:0];
            mem_wdata_d = wd_wide_s[DATA_WIDTH-1:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACC0: begin
        if (bus.mem_ack) begin
          rdata_d = cur_s;
`ifndef LSAU_MISALIGN_TRAP_EN
          if (split_s) begin
            state_d     = ACC1;
            mem_addr_d  = mem_addr_q + ADDR_WIDTH'(BYTES);
            mem_be_d    = be_wide_s[2*BYTES-1:BYTES];
            mem_wdata_d = wd_wide_s[2*DATA_WIDTH-1:DATA_WIDTH];
          end else
`endif
          begin
            finish_s = 1'b1;
          end
        end else begin
          state_d = ACC0;
        end
      end
`ifndef LSAU_MISALIGN_TRAP_EN
      ACC1: begin
        if (bus.mem_ack) finish_s = 1'b1;
        else             state_d  = ACC1;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (finish_s) begin
      state_d      = RESP;
      mem_req_d    = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = {ADDR_WIDTH{1'b0}};
      mem_be_d     = {BYTES{1'b0}};
      mem_wdata_d  = {DATA_WIDTH{1'b0}};
      resp_valid_d = 1'b1;
      resp_rdata_d = ld_s;
    end else begin
      resp_rdata_d = resp_rdata_d;
    end
  end

  // State and output registers; reset aborts any in-flight beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
      rdata_q      <= {DATA_WIDTH{1'b0}};
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_be_q     <= {BYTES{1'b0}};
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      signed_q     <= signed_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = idle_s;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: doc/load_store_align_unit.md
Name: load_store_align_unit

Overview:
- Parametrised load/store sizing and alignment unit between the datapath and the data memory port.
- Accepts one byte, half, word or (64-bit only) dword access per request.
- Generates byte enables and shifted write data; extracts and zero/sign-extends load data.
- Splits an access that crosses a memory-word boundary into two sequential memory transactions under a small FSM.

Parameters:
- DATA_WIDTH, 32, memory word and datapath width; legal values 32 or 64; BYTES = DATA_WIDTH/8, OFS_W = $clog2(BYTES).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 dword.
- req_signed  input  1  sign-extend load result.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  output  1  qualifies resp_valid; access illegal.
- mem_req  output  1  memory transaction request, held until mem_ack.
- mem_we  output  1  write transaction.
- mem_addr  output  ADDR_WIDTH  word-aligned address (low OFS_W bits 0).
- mem_be  output  BYTES  byte enables.
- mem_wdata  output  DATA_WIDTH  lane-aligned write data.
- mem_ack  input  1  transaction complete; mem_rdata valid in the same cycle.
- mem_rdata  input  DATA_WIDTH  read data, little-endian lanes.

Behaviour:
- Reset, asynchronous: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_req=0; mem_we=0; mem_addr=0; mem_be=0; mem_wdata=0.
- Reset mid-operation aborts the transaction; mem_req drops asynchronously; no response is issued.
- Definitions: n = 1<<req_size bytes; ofs = req_addr[OFS_W-1:0]; split = (ofs+n > BYTES); k = ofs+n-BYTES.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE: on req_valid&&req_ready, latch all request fields.
  - req_size=11 with DATA_WIDTH=32 -> RESP with resp_err=1; no memory transaction.
  - Otherwise -> ACC0.
- ACC0: mem_req=1; mem_we=req_write; mem_addr = addr with low OFS_W bits cleared.
  - mem_be = bytes ofs..min(ofs+n,BYTES)-1.
  - mem_wdata = wdata << (8*ofs).
  - On mem_ack: capture enabled read lanes; go to ACC1 if split, else RESP.
- ACC1: mem_addr = aligned addr + BYTES, wrapping modulo 2^ADDR_WIDTH.
  - mem_be = bytes 0..k-1.
  - mem_wdata = wdata >> (8*(n-k)).
  - On mem_ack -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Load data: assembled bytes, low address = low byte; zero-extended, or sign-extended from bit 8n-1 when req_signed.
- Latency: accept at cycle T; zero-wait aligned access responds at T+2; split access at T+3; each memory wait cycle adds one.
- mem_req, mem_addr, mem_be, mem_wdata and mem_we are registered and stable while mem_req=1 until ack.
- mem_ack outside ACC0/ACC1 is ignored.
- req_valid outside IDLE is ignored (req_ready=0); no request queueing.
- req_signed is ignored for stores and for n=BYTES.

Optional Feature:
- Macro: LSAU_MISALIGN_TRAP_EN.
- Defined: any split access goes IDLE -> RESP with resp_err=1 and issues no memory transaction; the ACC1 state is not built.
- Undefined: split accesses are performed as two transactions, as specified above.

Test Plan:
- Aligned word load, addr 0x100, mem_rdata 0xDEADBEEF, immediate ack -> one transaction, mem_addr 0x100, mem_be 1111, resp_rdata 0xDEADBEEF at T+2.
- Byte load, addr 0x103, mem_rdata 0x80123456 -> mem_be 1000; signed resp_rdata 0xFFFFFF80; unsigned resp_rdata 0x00000080.
- Misaligned word load, addr 0x102: ACC0 addr 0x100, be 1100, rdata 0x44330000; ACC1 addr 0x104, be 0011, rdata 0x00006655 -> resp_rdata 0x66554433 at T+3.
- Misaligned half store, addr 0x0FF, wdata 0x0000ABCD -> ACC0 addr 0x0FC, be 1000, wdata[31:24]=0xCD; ACC1 addr 0x100, be 0001, wdata[7:0]=0xAB; resp_valid with resp_err=0.
- req_size=11 with DATA_WIDTH=32 -> no mem_req; resp_err=1 at T+1; with LSAU_MISALIGN_TRAP_EN defined, a word load at 0x102 -> resp_err=1 and no mem_req.
- reset pulled low during ACC1 with mem_ack held low -> mem_req=0 immediately; after release req_ready=1 and no resp_valid pulse occurs.
